// File: rtl/cv32e40x_pkg.sv
// Shared types and constants for the clock-gating controller.
// Latency: none (types and constants only).
// Backpressure: none.
package cv32e40x_pkg;

    // Per-channel clock-gating state
    typedef enum logic [1:0] {
        CG_RUN   = 2'd0,
        CG_IDLE  = 2'd1,
        CG_GATED = 2'd2,
        CG_WAKE  = 2'd3
    } cg_state_e;

    // Width of each per-channel gated-cycle statistics counter
    localparam int unsigned CG_STAT_W = 32;

endpackage

// File: rtl/cv32e40x_clock_gate.sv
// Glitch-free clock gate cell: the enable is latched while clk_i is low, then ANDed with clk_i.
// Latency: an enable change takes effect on the next rising edge of clk_i.
// Backpressure: none; scan_cg_en_i forces the clock on regardless of en_i.
module cv32e40x_clock_gate (
    input  logic clk_i,
    input  logic en_i,
    input  logic scan_cg_en_i,
    output logic clk_o
);

    logic r_en_latch;

    // Enable latch: transparent only in the low phase so clk_o cannot glitch
    always_latch begin
        if (!clk_i) begin
            r_en_latch <= en_i | scan_cg_en_i;
        end
    end

    assign clk_o = clk_i & r_en_latch;

endmodule

// File: rtl/cv32e40x_clock_gate_ch.sv
// Single gated channel: idle hysteresis FSM, wake settle counter, optional gated-cycle statistics.
// Latency: gates HOLDOFF+1 cycles after idle begins; ready returns WAKE_CYCLES cycles after a wake.
// Backpressure: none; busy/wake are levels. Stats enabled by macro CV32E40X_CLK_GATE_STATS_EN.
module cv32e40x_clock_gate_ch
    import cv32e40x_pkg::*;
#(
    parameter int unsigned HOLDOFF     = 8,
    parameter int unsigned WAKE_CYCLES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 scan_cg_en_i,
    input  logic                 gate_allow_i,
    input  logic                 busy_i,
    input  logic                 wake_req_i,
    output logic                 clk_o,
    output logic                 ready_o,
    output logic                 gated_o,
    output logic [CG_STAT_W-1:0] gated_cycles_o
);

    localparam logic [CNT_W-1:0] LP_HOLD_LAST = CNT_W'(HOLDOFF - 1);
    localparam logic [CNT_W-1:0] LP_WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

    cg_state_e        r_state;
    cg_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_en;

    // Next-state and counter logic; the counter is cleared on every state change so it never wraps
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            CG_RUN: begin
                if (!busy_i && !wake_req_i && gate_allow_i) begin
                    w_state_nxt = CG_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            CG_IDLE: begin
                if (busy_i || wake_req_i || !gate_allow_i) begin
                    w_state_nxt = CG_RUN;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LP_HOLD_LAST) begin
                    w_state_nxt = CG_GATED;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            CG_GATED: begin
                // gate_allow_i deliberately ignored: only real work or a request wakes the channel
                if (busy_i || wake_req_i) begin
                    w_state_nxt = CG_WAKE;
                    w_cnt_nxt   = '0;
                end
            end
            CG_WAKE: begin
                // Settling: inputs ignored so the channel cannot re-gate mid-wake
                if (r_cnt == LP_WAKE_LAST) begin
                    w_state_nxt = CG_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = CG_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and registered clock enable; reset forces the clock back on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CG_RUN;
            r_cnt   <= '0;
            r_en    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_en    <= (w_state_nxt != CG_GATED);
        end
    end

    assign ready_o = (r_state == CG_RUN) || (r_state == CG_IDLE);
    assign gated_o = (r_state == CG_GATED);

    cv32e40x_clock_gate u_cg (
        .clk_i        (clk),
        .en_i         (r_en),
        .scan_cg_en_i (scan_cg_en_i),
        .clk_o        (clk_o)
    );

`ifdef CV32E40X_CLK_GATE_STATS_EN
    logic [CG_STAT_W-1:0] r_stat;

    // Saturating count of cycles spent gated; cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat <= '0;
        end else if (gated_o && (r_stat != {CG_STAT_W{1'b1}})) begin
            r_stat <= r_stat + CG_STAT_W'(1);
        end
    end

    assign gated_cycles_o = r_stat;
`else
    assign gated_cycles_o = '0;
`endif

endmodule

// File: rtl/cv32e40x_clock_gate_ctrl.sv
// Multi-channel clock-gating controller: NUM_CH independent gated clocks with idle hysteresis and wake handshake.
// Latency: per channel, gate after HOLDOFF+1 idle cycles; ready WAKE_CYCLES cycles after a wake event.
// Backpressure: none; ready_o low tells the consumer its clock is not yet settled. Macro CV32E40X_CLK_GATE_STATS_EN adds counters.
module cv32e40x_clock_gate_ctrl
    import cv32e40x_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned HOLDOFF     = 8,
    parameter int unsigned WAKE_CYCLES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          scan_cg_en_i,
    input  logic                          gate_allow_i,
    input  logic [NUM_CH-1:0]             busy_i,
    input  logic [NUM_CH-1:0]             wake_req_i,
    output logic [NUM_CH-1:0]             clk_o,
    output logic [NUM_CH-1:0]             ready_o,
    output logic [NUM_CH-1:0]             gated_o,
    output logic [NUM_CH*CG_STAT_W-1:0]   gated_cycles_o
);

    // One identical, fully independent controller per channel
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        cv32e40x_clock_gate_ch #(
            .HOLDOFF     (HOLDOFF),
            .WAKE_CYCLES (WAKE_CYCLES),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk            (clk),
            .rst_n          (rst_n),
            .scan_cg_en_i   (scan_cg_en_i),
            .gate_allow_i   (gate_allow_i),
            .busy_i         (busy_i[i]),
            .wake_req_i     (wake_req_i[i]),
            .clk_o          (clk_o[i]),
            .ready_o        (ready_o[i]),
            .gated_o        (gated_o[i]),
            .gated_cycles_o (gated_cycles_o[i*CG_STAT_W +: CG_STAT_W])
        );
    end

endmodule
